// File: rtl/glyph_pkg.sv
// Shared glyph geometry, row type and the font bitmap table used by the overlay ROM.
package glyph_pkg;

    localparam int GLYPH_W     = 16;
    localparam int GLYPH_H     = 16;
    localparam int FONT_GLYPHS = 32;
    localparam int FONT_IDX_W  = $clog2(FONT_GLYPHS);
    localparam int COL_W       = $clog2(GLYPH_W);
    localparam int ROW_W       = $clog2(GLYPH_H);
    localparam int FONT_DEPTH  = FONT_GLYPHS * GLYPH_H;

    typedef logic [GLYPH_W-1:0] glyph_row_t;
    typedef logic [FONT_DEPTH-1:0][GLYPH_W-1:0] font_t;

    // Font tool output: hashed filler rows (mostly background under active-low ink)
    // with the hand-drawn rows pinned afterwards.
    function automatic font_t gen_font();
        font_t       f;
        logic [31:0] h;
        for (int i = 0; i < FONT_DEPTH; i++) begin
            h    = 32'(i) * 32'h9E37_79B1;
            f[i] = h[31:16] | h[15:0];
        end
        f[3*GLYPH_H] = 16'hFFB7;
        f[7*GLYPH_H] = 16'hFFFF;
        return f;
    endfunction

    localparam font_t FONT = gen_font();

endpackage

// File: rtl/glyph_rom.sv
// Registered synchronous-read glyph ROM: one GLYPH_W-bit row word per {index,row}, 1-cycle latency.
module glyph_rom
    import glyph_pkg::*;
#(
    parameter int NUM_GLYPHS = FONT_GLYPHS,
    parameter int IDX_W      = FONT_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [ROW_W-1:0] row_i,
    output glyph_row_t       word_o
);

    localparam int DEPTH = NUM_GLYPHS * GLYPH_H;
    localparam int AW    = $clog2(DEPTH);

    glyph_row_t    rom [DEPTH];
    logic [AW-1:0] addr;
    glyph_row_t    word_d, word_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = FONT[i];
    end

    // Out-of-range indices read as zero rather than aliasing into another glyph.
    always_comb begin
        addr   = AW'({idx_i, row_i});
        word_d = '0;
        if (32'(idx_i) < 32'(NUM_GLYPHS)) word_d = rom[addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) word_q <= '0;
        else     word_q <= word_d;
    end

    assign word_o = word_q;

endmodule

// File: rtl/glyph_string_overlay.sv
// Text overlay: maps live pixel coordinates onto a programmable glyph string and keys
// ink colour over the video with a fixed 3-cycle latency.
module glyph_string_overlay #(
    parameter int GLYPH_W    = 16,
    parameter int GLYPH_H    = 16,
    parameter int NUM_GLYPHS = 32,
    parameter int IDX_W      = 5,
    parameter int MAX_CHARS  = 8,
    parameter int X_W        = 12,
    parameter int Y_W        = 12,
    parameter int INK_LOW    = 1,
    parameter int BLINK_BIT  = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(MAX_CHARS):0] wr_addr,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [$clog2(MAX_CHARS):0] str_len,
    input  logic [X_W-1:0]             box_x0,
    input  logic [Y_W-1:0]             box_y0,
    input  logic                       scale_sel,
    input  logic                       blink_en,
    input  logic [23:0]                ink_rgb,
    input  logic                       de_in,
    input  logic                       hs_in,
    input  logic                       vs_in,
    input  logic [X_W-1:0]             pix_x,
    input  logic [Y_W-1:0]             pix_y,
    input  logic [23:0]                rgb_in,
    output logic                       de_out,
    output logic                       hs_out,
    output logic                       vs_out,
    output logic [23:0]                rgb_out,
    output logic                       ink_out
);

    import glyph_pkg::*;

    localparam int LEN_W    = $clog2(MAX_CHARS) + 1;
    localparam int SEL_W    = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
    localparam int COL_BITS = $clog2(GLYPH_W);
    localparam int ROW_BITS = $clog2(GLYPH_H);
    localparam int VID_W    = 27;

    logic [IDX_W-1:0] slot_q [MAX_CHARS];

    // S0: coordinate stage
    logic [LEN_W-1:0]    eff_len;
    logic [X_W:0]        dx, slot_wide;
    logic [Y_W:0]        dy;
    logic [31:0]         box_w, box_h;
    logic                in_box;
    logic [IDX_W-1:0]    slot_idx;
    logic [COL_BITS-1:0] col0;
    logic [ROW_BITS-1:0] row0;

    always_comb begin
        eff_len   = (str_len > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : str_len;
        dx        = {1'b0, pix_x} - {1'b0, box_x0};
        dy        = {1'b0, pix_y} - {1'b0, box_y0};
        box_w     = 32'(eff_len) << (COL_BITS + int'(scale_sel));
        box_h     = 32'(GLYPH_H) << scale_sel;
        in_box    = de_in && (pix_x >= box_x0) && (pix_y >= box_y0) &&
                    (32'(dx) < box_w) && (32'(dy) < box_h);
        col0      = COL_BITS'(dx >> scale_sel);
        row0      = ROW_BITS'(dy >> scale_sel);
        slot_wide = (dx >> scale_sel) >> COL_BITS;
        slot_idx  = '0;
        if (slot_wide < (X_W+1)'(MAX_CHARS)) slot_idx = slot_q[SEL_W'(slot_wide)];
    end

    // The S1 capture below reads slot_q before this edge's write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_CHARS; i++) slot_q[i] <= '0;
        end else if (wr_en && (wr_addr < LEN_W'(MAX_CHARS))) begin
            slot_q[SEL_W'(wr_addr)] <= wr_idx;
        end
    end

    // S1/S2 registers and the video delay line
    logic [IDX_W-1:0]          idx1_q;
    logic [ROW_BITS-1:0]       row1_q;
    logic [COL_BITS-1:0]       col1_q, col2_q;
    logic                      box1_q, box2_q;
    logic [1:0][VID_W-1:0]     vid_q;
    glyph_row_t                rom_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx1_q <= '0;
            row1_q <= '0;
            col1_q <= '0;
            col2_q <= '0;
            box1_q <= 1'b0;
            box2_q <= 1'b0;
            vid_q  <= '0;
        end else begin
            idx1_q <= slot_idx;
            row1_q <= row0;
            col1_q <= col0;
            box1_q <= in_box && (32'(slot_idx) < 32'(NUM_GLYPHS));
            col2_q <= col1_q;
            box2_q <= box1_q;
            vid_q  <= {vid_q[0], {de_in, hs_in, vs_in, rgb_in}};
        end
    end

    glyph_rom #(
        .NUM_GLYPHS(NUM_GLYPHS),
        .IDX_W     (IDX_W)
    ) u_rom (
        .clk   (clk),
        .rst   (rst),
        .idx_i (idx1_q),
        .row_i (row1_q),
        .word_o(rom_word)
    );

    // S3: output stage and frame counter
    logic [BLINK_BIT:0] frame_cnt_q;
    logic               vs_prev_q;
    logic               ink_d;
    logic [23:0]        rgb_d;
    logic               de_q, hs_q, vs_q, ink_q;
    logic [23:0]        rgb_q;

    // ~col picks bit GLYPH_W-1-col because GLYPH_W is a power of two (MSB is leftmost).
    always_comb begin
        ink_d = box2_q && (rom_word[~col2_q] ^ 1'(INK_LOW)) &&
                !(blink_en && frame_cnt_q[BLINK_BIT]);
        rgb_d = ink_d ? ink_rgb : vid_q[1][23:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            vs_prev_q   <= 1'b0;
            de_q        <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            ink_q       <= 1'b0;
            rgb_q       <= '0;
        end else begin
            vs_prev_q <= vs_in;
            if (vs_in && !vs_prev_q) frame_cnt_q <= frame_cnt_q + 1'b1;
            de_q  <= vid_q[1][26];
            hs_q  <= vid_q[1][25];
            vs_q  <= vid_q[1][24];
            ink_q <= ink_d;
            rgb_q <= rgb_d;
        end
    end

    assign de_out  = de_q;
    assign hs_out  = hs_q;
    assign vs_out  = vs_q;
    assign ink_out = ink_q;
    assign rgb_out = rgb_q;

endmodule

// File: tb/tb_glyph_string_overlay.sv
// Self-checking bench: hand-derived vector table, directed corner sequences and a randomized
// scan against a divide-and-modulo pixel reference model with a 3-deep expected pipeline.
module tb_glyph_string_overlay;
    import glyph_pkg::*;

    localparam int NG = 18;
    localparam int MC = 8;
    localparam int BB = 5;
    localparam int LW = $clog2(MC) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en, scale_sel, blink_en, de_in, hs_in, vs_in;
    logic [LW-1:0] wr_addr, str_len;
    logic [4:0]    wr_idx;
    logic [11:0]   box_x0, box_y0, pix_x, pix_y;
    logic [23:0]   ink_rgb, rgb_in, rgb_out;
    logic          de_out, hs_out, vs_out, ink_out;

    always #5 clk = ~clk;

    glyph_string_overlay #(.NUM_GLYPHS(NG), .MAX_CHARS(MC), .BLINK_BIT(BB)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_idx(wr_idx),
        .str_len(str_len), .box_x0(box_x0), .box_y0(box_y0), .scale_sel(scale_sel),
        .blink_en(blink_en), .ink_rgb(ink_rgb), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
        .pix_x(pix_x), .pix_y(pix_y), .rgb_in(rgb_in), .de_out(de_out), .hs_out(hs_out),
        .vs_out(vs_out), .rgb_out(rgb_out), .ink_out(ink_out)
    );

    typedef struct { logic de; logic hs; logic vs; logic [23:0] rgb; logic raw; } exp_t;
    typedef struct { logic sc; int x; int y; logic ink; } vec_t;

    exp_t       pipe [$];
    logic [4:0] m_slot [MC];
    int         m_frames;
    logic       m_vs_prev;
    int         total = 0;
    int         bad = 0;
    int         ink_acc = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
        end
    endtask

    // Ink before blink, from the rules: box bounds, then integer divide/modulo to glyph cell.
    function automatic logic model_raw();
        int sc, len, dx, dy, c, slot, col, row, g;
        logic [15:0] w;
        if (!de_in) return 1'b0;
        if (pix_x < box_x0 || pix_y < box_y0) return 1'b0;
        sc  = scale_sel ? 2 : 1;
        len = (int'(str_len) > MC) ? MC : int'(str_len);
        dx  = int'(pix_x) - int'(box_x0);
        dy  = int'(pix_y) - int'(box_y0);
        if (dx >= len * GLYPH_W * sc || dy >= GLYPH_H * sc) return 1'b0;
        c    = dx / sc;
        slot = c / GLYPH_W;
        col  = c % GLYPH_W;
        row  = (dy / sc) % GLYPH_H;
        g    = int'(m_slot[slot]);
        if (g >= NG) return 1'b0;
        w = FONT[g * GLYPH_H + row];
        return w[GLYPH_W - 1 - col] == 1'b0;
    endfunction

    task automatic model_reset();
        exp_t z;
        z = '{de: 1'b0, hs: 1'b0, vs: 1'b0, rgb: 24'h0, raw: 1'b0};
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
        for (int i = 0; i < MC; i++) m_slot[i] = '0;
        m_frames  = 0;
        m_vs_prev = 1'b0;
    endtask

    // One clock: queue this pixel's expectation, retire the one whose output lands at this edge.
    task automatic tick();
        exp_t        e, f;
        logic        eink;
        logic [23:0] ergb;
        e = '{de: de_in, hs: hs_in, vs: vs_in, rgb: rgb_in, raw: model_raw()};
        pipe.push_back(e);
        f    = pipe.pop_front();
        eink = f.raw && !(blink_en && (((m_frames >> BB) & 1) == 1));
        ergb = eink ? ink_rgb : f.rgb;
        if (wr_en && int'(wr_addr) < MC) m_slot[int'(wr_addr)] = wr_idx;
        if (vs_in && !m_vs_prev) m_frames = (m_frames + 1) % 64;
        m_vs_prev = vs_in;
        @(posedge clk);
        #1;
        ink_acc += int'(ink_out);
        check("pipe", 64'({de_out, hs_out, vs_out, ink_out, rgb_out}),
              64'({f.de, f.hs, f.vs, eink, ergb}));
    endtask

    task automatic wr(input int a, input int idx);
        wr_en   = 1'b1;
        wr_addr = LW'(a);
        wr_idx  = 5'(idx);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        de_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic scan(input int x0, input int x1, input int y);
        for (int x = x0; x <= x1; x++) begin
            de_in  = 1'b1;
            pix_x  = 12'(x);
            pix_y  = 12'(y);
            rgb_in = 24'($urandom);
            tick();
        end
        idle(3);
    endtask

    initial begin
        vec_t        tv [16];
        logic [23:0] saved;
        int          cnt_on, cnt_off;

        tv = '{ '{1'b0,  99, 50, 1'b0}, '{1'b0, 100, 50, 1'b0}, '{1'b0, 101, 50, 1'b0},
                '{1'b0, 109, 50, 1'b1}, '{1'b0, 110, 50, 1'b0}, '{1'b0, 112, 50, 1'b1},
                '{1'b0, 116, 50, 1'b0}, '{1'b0, 131, 50, 1'b0}, '{1'b0, 132, 50, 1'b0},
                '{1'b1, 118, 50, 1'b1}, '{1'b1, 119, 51, 1'b1}, '{1'b1, 124, 51, 1'b1},
                '{1'b1, 125, 50, 1'b1}, '{1'b1, 120, 50, 1'b0}, '{1'b1, 163, 50, 1'b0},
                '{1'b1, 164, 50, 1'b0} };

        wr_en = 1'b0; wr_addr = '0; wr_idx = '0; str_len = '0; box_x0 = '0; box_y0 = '0;
        scale_sel = 1'b0; blink_en = 1'b0; ink_rgb = 24'hFF00FF; de_in = 1'b0; hs_in = 1'b0;
        vs_in = 1'b0; pix_x = '0; pix_y = '0; rgb_in = 24'h0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 64'({de_out, hs_out, vs_out, ink_out, rgb_out}), 64'd0);
        rst = 1'b0;
        model_reset();

        wr(0, 3);
        wr(1, 7);
        str_len = LW'(2); box_x0 = 12'd100; box_y0 = 12'd50;
        idle(3);

        // Hand-derived table: glyph 3 row 0 = FFB7 inks cols 9 and 12; glyph 7 row 0 is blank.
        for (int i = 0; i < 16; i++) begin
            scale_sel = tv[i].sc;
            pix_x     = 12'(tv[i].x);
            pix_y     = 12'(tv[i].y);
            de_in     = 1'b1;
            rgb_in    = 24'($urandom);
            saved     = rgb_in;
            tick();
            idle(2);
            check("tbl_ink", 64'(ink_out), 64'(tv[i].ink));
            check("tbl_rgb", 64'(rgb_out), 64'(tv[i].ink ? ink_rgb : saved));
        end
        scale_sel = 1'b0;

        // Blink: frames 32..63 suppress ink; two ink pixels per visible frame.
        blink_en = 1'b1;
        cnt_on   = 0;
        cnt_off  = 0;
        for (int f = 1; f <= 64; f++) begin
            vs_in = 1'b1;
            tick();
            vs_in = 1'b0;
            idle(1);
            ink_acc = 0;
            scan(109, 109, 50);
            scan(112, 112, 50);
            scan(101, 101, 50);
            if (f >= 32 && f <= 63) cnt_off += ink_acc;
            else                    cnt_on  += ink_acc;
        end
        check("blink_off", 64'(cnt_off), 64'd0);
        check("blink_on", 64'(cnt_on), 64'd64);
        blink_en = 1'b0;

        // Out-of-range glyph renders blank; out-of-range slot address changes nothing.
        wr(2, 31);
        wr(9, 5);
        str_len = LW'(3);
        idle(3);
        ink_acc = 0;
        for (int y = 50; y <= 52; y++) scan(132, 147, y);
        check("blank_idx31", 64'(ink_acc), 64'd0);
        ink_acc = 0;
        scan(100, 131, 50);
        check("addr9_ignored", 64'(ink_acc), 64'd2);

        // Randomized scan around the box, with writes, config changes and occasional vsync.
        for (int n = 0; n < 1500; n++) begin
            wr_en   = ($urandom_range(0, 15) == 0);
            wr_addr = LW'($urandom_range(0, 15));
            wr_idx  = 5'($urandom);
            if ($urandom_range(0, 63) == 0) str_len = LW'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) scale_sel = 1'($urandom);
            if ($urandom_range(0, 99) == 0) blink_en = 1'($urandom);
            if ($urandom_range(0, 99) == 0) ink_rgb = 24'($urandom);
            vs_in  = ($urandom_range(0, 99) == 0);
            hs_in  = 1'($urandom);
            de_in  = ($urandom_range(0, 7) != 0);
            pix_x  = 12'(90 + $urandom_range(0, 300));
            pix_y  = 12'(45 + $urandom_range(0, 45));
            rgb_in = 24'($urandom);
            tick();
        end
        wr_en = 1'b0; vs_in = 1'b0; hs_in = 1'b0; blink_en = 1'b0;
        idle(3);

        // Box near the right edge of the coordinate space must not wrap to x = 0.
        for (int i = 0; i < MC; i++) wr(i, 0);
        box_x0 = 12'd4090; box_y0 = 12'd0; str_len = LW'(8); scale_sel = 1'b1;
        idle(3);
        ink_acc = 0;
        scan(0, 40, 3);
        check("no_wrap", 64'(ink_acc), 64'd0);
        scan(4088, 4095, 3);

        // Mid-line reset clears outputs asynchronously.
        box_x0 = 12'd100; box_y0 = 12'd50; scale_sel = 1'b0; str_len = LW'(2);
        for (int x = 100; x <= 104; x++) begin
            de_in = 1'b1; pix_x = 12'(x); pix_y = 12'd50; rgb_in = 24'($urandom);
            tick();
        end
        de_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_async", 64'({de_out, hs_out, vs_out, ink_out, rgb_out}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Slots read 0 after reset (glyph 0 row 0 is all ink); first output 3 cycles later.
        str_len = LW'(1);
        de_in = 1'b1; pix_x = 12'd100; pix_y = 12'd50; rgb_in = 24'h123456;
        tick();
        check("lat_c1", 64'(de_out), 64'd0);
        de_in = 1'b0;
        tick();
        check("lat_c2", 64'(de_out), 64'd0);
        tick();
        check("lat_c3", 64'({de_out, ink_out, rgb_out}), 64'({1'b1, 1'b1, ink_rgb}));
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
